// File: rtl/cheri_branch_sequencer.sv
// Buffers branch/jump operations from issue and presents one at a time to the CHERI branch unit.
// Define CHERI_BRANCH_SEQ_STATS_EN to add saturating mispredict/exception counters.
module cheri_branch_sequencer #(
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned PAYLOAD_W     = 64,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
  input  logic [PAYLOAD_W-1:0]     req_payload_i,
  output logic                     bu_valid_o,
  output logic [TRANS_ID_BITS-1:0] bu_trans_id_o,
  output logic [PAYLOAD_W-1:0]     bu_payload_o,
  input  logic                     bu_resolve_i,
  input  logic                     bu_mispredict_i,
  input  logic                     bu_ex_valid_i,
  output logic                     done_valid_o,
  output logic [TRANS_ID_BITS-1:0] done_trans_id_o,
  output logic                     done_kill_o,
  output logic                     flush_younger_o
`ifdef CHERI_BRANCH_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]         stat_mispredict_o,
  output logic [CNT_W-1:0]         stat_cap_ex_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_SQUASH
  } state_e;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [PAYLOAD_W-1:0]     payload;
  } entry_t;

  entry_t                   mem_q [DEPTH];
  entry_t                   head;
  logic   [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  state_e                   state_q, state_d;
  logic                     full, push, kill, resolve_fire;
  logic                     done_valid_q, done_kill_q;
  logic [TRANS_ID_BITS-1:0] done_id_q;

  assign full = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
  assign head = mem_q[rptr_q[IDX_W-1:0]];

  assign req_ready_o  = !full && (state_q != S_SQUASH) && !flush_i;
  assign push         = req_valid_i && req_ready_o;
  assign kill         = bu_mispredict_i || bu_ex_valid_i;
  assign resolve_fire = (state_q == S_BUSY) && bu_resolve_i && !flush_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = rptr_q;
    if (flush_i) begin
      rptr_d  = wptr_q;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (wptr_d != rptr_d) state_d = S_BUSY;
        end
        S_BUSY: begin
          if (bu_resolve_i) begin
            rptr_d = rptr_q + 1'b1;
            if (kill)                  state_d = S_SQUASH;
            else if (wptr_d != rptr_d) state_d = S_BUSY;
            else                       state_d = S_IDLE;
          end
        end
        S_SQUASH: begin
          // Drops every younger entry, including one accepted alongside the kill.
          rptr_d  = wptr_q;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: the entry storage has no reset; pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[IDX_W-1:0]] <= '{trans_id: req_trans_id_i, payload: req_payload_i};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      done_valid_q <= 1'b0;
      done_kill_q  <= 1'b0;
      done_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      done_valid_q <= resolve_fire;
      done_kill_q  <= resolve_fire && kill;
      if (resolve_fire) done_id_q <= head.trans_id;
    end
  end

  assign bu_valid_o      = (state_q == S_BUSY);
  assign bu_trans_id_o   = bu_valid_o ? head.trans_id : '0;
  assign bu_payload_o    = bu_valid_o ? head.payload  : '0;
  assign done_valid_o    = done_valid_q;
  assign done_trans_id_o = done_id_q;
  assign done_kill_o     = done_kill_q;
  assign flush_younger_o = (state_q == S_SQUASH);

`ifdef CHERI_BRANCH_SEQ_STATS_EN
  logic [CNT_W-1:0] stat_mis_q, stat_ex_q;

  // Counters saturate and deliberately survive flush_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_mis_q <= '0;
      stat_ex_q  <= '0;
    end else begin
      if (resolve_fire && bu_mispredict_i && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + 1'b1;
      if (resolve_fire && bu_ex_valid_i   && (stat_ex_q  != '1)) stat_ex_q  <= stat_ex_q + 1'b1;
    end
  end

  assign stat_mispredict_o = stat_mis_q;
  assign stat_cap_ex_o     = stat_ex_q;
`endif

endmodule

// File: tb/tb_cheri_branch_sequencer.sv
// Scoreboard bench for cheri_branch_sequencer: queue-based reference model plus a decoupled done monitor.
module tb_cheri_branch_sequencer;

  localparam int DEPTH = 2;
  localparam int IDW   = 3;
  localparam int PW    = 64;
`ifdef CHERI_BRANCH_SEQ_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           flush_i = 1'b0;
  logic           req_valid_i = 1'b0;
  logic [IDW-1:0] req_trans_id_i = '0;
  logic [PW-1:0]  req_payload_i = '0;
  logic           bu_resolve_i = 1'b0;
  logic           bu_mispredict_i = 1'b0;
  logic           bu_ex_valid_i = 1'b0;
  logic           req_ready_o, bu_valid_o, done_valid_o, done_kill_o, flush_younger_o;
  logic [IDW-1:0] bu_trans_id_o, done_trans_id_o;
  logic [PW-1:0]  bu_payload_o;
`ifdef CHERI_BRANCH_SEQ_STATS_EN
  logic [CW-1:0]  stat_mispredict_o, stat_cap_ex_o;
`endif

  cheri_branch_sequencer #(
    .DEPTH(DEPTH), .TRANS_ID_BITS(IDW), .PAYLOAD_W(PW), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_trans_id_i(req_trans_id_i), .req_payload_i(req_payload_i),
    .bu_valid_o(bu_valid_o), .bu_trans_id_o(bu_trans_id_o), .bu_payload_o(bu_payload_o),
    .bu_resolve_i(bu_resolve_i), .bu_mispredict_i(bu_mispredict_i), .bu_ex_valid_i(bu_ex_valid_i),
    .done_valid_o(done_valid_o), .done_trans_id_o(done_trans_id_o), .done_kill_o(done_kill_o),
    .flush_younger_o(flush_younger_o)
`ifdef CHERI_BRANCH_SEQ_STATS_EN
    ,
    .stat_mispredict_o(stat_mispredict_o), .stat_cap_ex_o(stat_cap_ex_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [IDW-1:0] id;
    logic [PW-1:0]  pl;
  } op_t;
  typedef struct {
    logic [IDW-1:0] id;
    logic           kill;
  } done_t;

  op_t    fifo_m[$];
  done_t  exp_q[$];
  bit     busy_m, squash_m;
  longint stat_mis_m, stat_ex_m;
  longint cnt_max = longint'((65'd1 << CW) - 1);
  int     n_checks = 0;
  int     n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    fifo_m.delete();
    exp_q.delete();
    busy_m     = 1'b0;
    squash_m   = 1'b0;
    stat_mis_m = 0;
    stat_ex_m  = 0;
  endtask

  // Checks the cycle's combinational outputs, then advances the model across the clock edge.
  task automatic cycle();
    bit exp_ready, fire, kl;
    #1;
    exp_ready = (fifo_m.size() < DEPTH) && !squash_m && !flush_i;
    check("req_ready", req_ready_o, exp_ready);
    check("bu_valid", bu_valid_o, busy_m);
    if (busy_m && fifo_m.size() > 0) begin
      check("bu_trans_id", bu_trans_id_o, fifo_m[0].id);
      check("bu_payload", bu_payload_o, fifo_m[0].pl);
    end else begin
      check("bu_trans_id_idle", bu_trans_id_o, 0);
      check("bu_payload_idle", bu_payload_o, 0);
    end
    check("flush_younger", flush_younger_o, squash_m);
`ifdef CHERI_BRANCH_SEQ_STATS_EN
    check("stat_mispredict", stat_mispredict_o, stat_mis_m);
    check("stat_cap_ex", stat_cap_ex_o, stat_ex_m);
`endif
    @(posedge clk_i);
    if (flush_i || squash_m) begin
      fifo_m.delete();
      busy_m   = 1'b0;
      squash_m = 1'b0;
    end else begin
      fire = busy_m && bu_resolve_i;
      kl   = fire && (bu_mispredict_i || bu_ex_valid_i);
      if (fire) begin
        exp_q.push_back('{fifo_m[0].id, kl});
        void'(fifo_m.pop_front());
        if (bu_mispredict_i && stat_mis_m < cnt_max) stat_mis_m++;
        if (bu_ex_valid_i && stat_ex_m < cnt_max) stat_ex_m++;
      end
      if (req_valid_i && exp_ready) fifo_m.push_back('{req_trans_id_i, req_payload_i});
      if (kl) begin
        squash_m = 1'b1;
        busy_m   = 1'b0;
      end else begin
        busy_m = fifo_m.size() > 0;
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input int id, input bit res, input bit mis, input bit ex,
                       input bit fl);
    req_valid_i     = v;
    req_trans_id_i  = IDW'(id);
    req_payload_i   = {$urandom, $urandom};
    bu_resolve_i    = res;
    bu_mispredict_i = mis;
    bu_ex_valid_i   = ex;
    flush_i         = fl;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  // Done monitor: completion must appear exactly the cycle after the model predicts it.
  always @(negedge clk_i) begin
    done_t e;
    if (rst_ni && (done_valid_o || exp_q.size() != 0)) begin
      check("done_valid", done_valid_o, exp_q.size() != 0);
      if (done_valid_o && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("done_trans_id", done_trans_id_o, e.id);
        check("done_kill", done_kill_o, e.kill);
      end else begin
        exp_q.delete();
      end
    end
  end

  initial begin
    model_reset();
    #2;
    check("rst_req_ready", req_ready_o, 1);
    check("rst_bu_valid", bu_valid_o, 0);
    check("rst_done_valid", done_valid_o, 0);
    check("rst_done_kill", done_kill_o, 0);
    check("rst_done_id", done_trans_id_o, 0);
    check("rst_flush_younger", flush_younger_o, 0);
    #10 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    idle(10);

    // Back-to-back ids 1,2,3 with resolve tied high.
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 2, 1, 0, 0, 0);
    drive(1, 3, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle(3);

    // Fill DEPTH=2 with resolve low; third request must stall until the first resolve.
    drive(1, 6, 0, 0, 0, 0);
    drive(1, 7, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0);
    idle(2);

    // Mispredict on 4 squashes buffered 5.
    drive(1, 4, 0, 0, 0, 0);
    drive(1, 5, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    idle(4);

    // Kill resolve with a simultaneous accepted request: that request is dropped too.
    drive(1, 2, 0, 0, 0, 0);
    drive(1, 3, 1, 0, 1, 0);
    idle(3);

    // flush_i wins over a simultaneous exception resolve.
    drive(1, 2, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 1);
    idle(3);

    // Enough mispredicts to saturate a narrow statistics counter.
    for (int i = 0; i < 20; i++) begin
      drive(1, i, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
    end
    idle(2);

    // Asynchronous reset mid-operation.
    drive(1, 5, 0, 0, 0, 0);
    drive(1, 6, 0, 0, 0, 0);
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("async_rst_bu_valid", bu_valid_o, 0);
    check("async_rst_bu_id", bu_trans_id_o, 0);
    check("async_rst_req_ready", req_ready_o, 1);
    check("async_rst_done_valid", done_valid_o, 0);
    #2 rst_ni = 1'b1;
    idle(3);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 3) != 0, int'($urandom % 8), $urandom % 2,
            ($urandom % 8) == 0, ($urandom % 10) == 0, ($urandom % 25) == 0);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 0);
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cheri_branch_sequencer.md
# cheri_branch_sequencer

Sequencing front-end for the CHERI branch unit. It buffers branch/jump operations coming from issue, presents exactly one at a time to the branch unit and holds it until the unit resolves it. On a mispredict or a capability exception it squashes every younger buffered branch. It sits between issue and the branch unit inside the execute stage and optionally keeps performance counters.

## Interface
- DEPTH, 2: number of buffered branch operations; power of two, at least 2.
- TRANS_ID_BITS, 3: scoreboard transaction-id width.
- PAYLOAD_W, 64: width of the opaque payload (operator, imm, predict info), passed through unchanged.
- CNT_W, 32: statistics counter width.

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  global pipeline flush
- req_valid_i  in  1  issue offers a branch operation
- req_ready_o  out  1  sequencer accepts it this cycle
- req_trans_id_i  in  TRANS_ID_BITS  id of the offered operation
- req_payload_i  in  PAYLOAD_W  opaque operation payload
- bu_valid_o  out  1  operation presented to the branch unit (fu_valid/branch_valid)
- bu_trans_id_o  out  TRANS_ID_BITS  id of the presented operation
- bu_payload_o  out  PAYLOAD_W  payload of the presented operation
- bu_resolve_i  in  1  branch unit resolved the presented operation
- bu_mispredict_i  in  1  resolved_branch.is_mispredict, qualified by bu_resolve_i
- bu_ex_valid_i  in  1  branch_exception.valid, qualified by bu_resolve_i
- done_valid_o  out  1  completion pulse
- done_trans_id_o  out  TRANS_ID_BITS  id of the completed operation
- done_kill_o  out  1  completion was a mispredict or an exception
- flush_younger_o  out  1  younger buffered branches were squashed
- stat_mispredict_o  out  CNT_W  mispredict count (present only with the macro)
- stat_cap_ex_o  out  CNT_W  exception count (present only with the macro)

## Operation
- Circular FIFO of DEPTH entries, each holding {trans_id, payload}. Read and write pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
- req_ready_o = !full && state != SQUASH && !flush_i.
- Enqueue on req_valid_i && req_ready_o.
- FSM states:
  - IDLE: FIFO head not presented. Goes to BUSY when the FIFO is non-empty.
  - BUSY: head presented with bu_valid_o = 1; bu_* outputs stay stable until bu_resolve_i.
    - Resolve, no kill: pop head, pulse done, done_kill_o = 0. Go to BUSY if another entry remains, otherwise IDLE (back-to-back issue).
    - Resolve with bu_mispredict_i or bu_ex_valid_i: pop head, pulse done, done_kill_o = 1, go to SQUASH.
  - SQUASH: one cycle. flush_younger_o = 1, read pointer set to write pointer (all younger entries dropped), no enqueue, then IDLE.
- A request accepted in the same cycle as a kill resolve is also dropped in SQUASH.
- flush_i: from any state, FIFO emptied, FSM to IDLE, no done pulse. flush_i has priority over a simultaneous resolve.
- bu_resolve_i while not BUSY is ignored.

## Timing
- Reset values:
  - FIFO empty, state IDLE, req_ready_o = 1.
  - bu_valid_o = 0, done_valid_o = 0, done_kill_o = 0, flush_younger_o = 0.
  - bu_trans_id_o = 0, bu_payload_o = 0, done_trans_id_o = 0.
  - Stat counters = 0.
- Enqueue into an empty IDLE sequencer: bu_valid_o rises the next cycle (1-cycle latency).
- bu_resolve_i may arrive in the first BUSY cycle (0-cycle branch unit) or any later cycle.
- done_* outputs are registered: they appear the cycle after resolve and last one cycle.
- Back-to-back operation: one operation per cycle while the FIFO holds entries and no kill occurs.
- After a kill resolve, the next enqueue is possible 2 cycles later (SQUASH cycle, then IDLE).
- Reset asserted mid-operation returns everything to reset values immediately, asynchronously.

## Configuration
- CHERI_BRANCH_SEQ_STATS_EN defined:
  - stat_mispredict_o increments on each resolve with bu_mispredict_i.
  - stat_cap_ex_o increments on each resolve with bu_ex_valid_i.
  - Both counters saturate at all-ones and are not cleared by flush_i.
- Not defined: both stat ports are absent and no counter logic is generated.

## Test plan
- Reset then idle: all outputs at reset values, req_ready_o = 1, bu_valid_o = 0 for 10 cycles.
- Enqueue ids 1, 2, 3 back-to-back, bu_resolve_i tied 1 with no kill: bu_trans_id_o is 1, 2, 3 on consecutive cycles; done pulses for 1, 2, 3 one cycle later each; done_kill_o = 0.
- DEPTH = 2, bu_resolve_i held low: third request sees req_ready_o = 0 until the first resolve; bu_payload_o stays stable throughout.
- Buffer ids 4 and 5, resolve 4 with bu_mispredict_i = 1: done id 4 with done_kill_o = 1, next cycle flush_younger_o = 1, id 5 never presented, stat_mispredict_o = 1.
- flush_i in the same cycle as bu_resolve_i with bu_ex_valid_i = 1: no done pulse, FIFO empty, IDLE next cycle, no flush_younger_o.
- Force the statistics counter to all-ones, then mispredict: it stays all-ones.
